// File: rtl/contador_descendente_if.sv
// Control/status bundle for the loadable down-counter/timer.
// The master drives the controls, and the slave (the timer) returns the count and status.
interface contador_descendente_if #(
  parameter int WIDTH = 12
);
  logic             enable;
  logic             loadbit;
  logic [WIDTH-1:0] load;
  logic             mode;
  logic [WIDTH-1:0] cont;
  logic             tc;
  logic             busy;
  logic             done;

  modport master (
    output enable, loadbit, load, mode,
    input  cont, tc, busy, done
  );

  modport slave (
    input  enable, loadbit, load, mode,
    output cont, tc, busy, done
  );
endinterface

// File: rtl/contador_descendente.sv
// Loadable 12-bit down-counter/timer with a terminal-count pulse and one-shot or periodic reload.
//   state | meaning
//   IDLE  | nothing loaded (or load of 0); enable ignored
//   ARMED | value loaded, no decrement yet
//   RUN   | counting down; periodic timers stay here across reloads
//   DONE  | one-shot expired; cont held at 0 until the next load or reset
module contador_descendente #(
  parameter int WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  contador_descendente_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cont_q, cont_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             tc_q, tc_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cont_q   <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cont_q   <= cont_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      tc_q     <= tc_d;
    end
  end

  // A load takes priority over enable. In ARMED/RUN the count is always >= 1.
  always_comb begin
    state_d  = state_q;
    cont_d   = cont_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    tc_d     = 1'b0;
    if (bus.loadbit) begin
      cont_d   = bus.load;
      reload_d = bus.load;
      mode_d   = bus.mode;
      state_d  = (bus.load != '0) ? ARMED : IDLE;
    end else if (bus.enable && (state_q == ARMED || state_q == RUN)) begin
      if (cont_q > WIDTH'(1)) begin
        cont_d  = cont_q - WIDTH'(1);
        state_d = RUN;
      end else begin
        tc_d = 1'b1;
        if (mode_q) begin
          cont_d  = reload_q;
          state_d = RUN;
        end else begin
          cont_d  = '0;
          state_d = DONE;
        end
      end
    end
  end

  always_comb begin
    bus.cont = cont_q;
    bus.tc   = tc_q;
    bus.busy = (state_q == ARMED) || (state_q == RUN);
    bus.done = (state_q == DONE);
  end

endmodule

// File: tb/tb_contador_descendente.sv
// Scoreboard bench for contador_descendente: a behavioural model queues the expected outputs
// for each edge, and the outputs are popped and compared 1 time unit after that edge.
module tb_contador_descendente;
  localparam int WIDTH = 12;
  localparam int S_IDLE = 0, S_ARMED = 1, S_RUN = 2, S_DONE = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  contador_descendente_if #(.WIDTH(WIDTH)) bus ();
  contador_descendente #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    string            tag;
    logic [WIDTH-1:0] cont;
    logic             tc;
    logic             busy;
    logic             done;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  int               m_state  = S_IDLE;
  logic [WIDTH-1:0] m_cont   = '0;
  logic [WIDTH-1:0] m_reload = '0;
  logic             m_mode   = 1'b0;
  logic             m_tc     = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic en, input logic lb,
                       input logic [WIDTH-1:0] ld, input logic md);
    if (r) begin
      m_state = S_IDLE; m_cont = '0; m_reload = '0; m_mode = 1'b0; m_tc = 1'b0;
    end else if (lb) begin
      m_cont = ld; m_reload = ld; m_mode = md; m_tc = 1'b0;
      m_state = (ld != 0) ? S_ARMED : S_IDLE;
    end else if (en && (m_state == S_ARMED || m_state == S_RUN)) begin
      if (m_cont > 1) begin
        m_cont = m_cont - 1; m_state = S_RUN; m_tc = 1'b0;
      end else if (m_mode) begin
        m_cont = m_reload; m_state = S_RUN; m_tc = 1'b1;
      end else begin
        m_cont = '0; m_state = S_DONE; m_tc = 1'b1;
      end
    end else begin
      m_tc = 1'b0;
    end
  endtask

  task automatic step(input string tag, input logic r, input logic en, input logic lb,
                      input logic [WIDTH-1:0] ld, input logic md);
    exp_t e;
    reset = r; bus.enable = en; bus.loadbit = lb; bus.load = ld; bus.mode = md;
    model(r, en, lb, ld, md);
    e.tag  = tag;
    e.cont = m_cont;
    e.tc   = m_tc;
    e.busy = (m_state == S_ARMED) || (m_state == S_RUN);
    e.done = (m_state == S_DONE);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, ".cont"}, 32'(bus.cont), 32'(e.cont));
    check({e.tag, ".tc"},   32'(bus.tc),   32'(e.tc));
    check({e.tag, ".busy"}, 32'(bus.busy), 32'(e.busy));
    check({e.tag, ".done"}, 32'(bus.done), 32'(e.done));
  endtask

  task automatic load_val(input string tag, input logic [WIDTH-1:0] ld, input logic md,
                          input logic en);
    step(tag, 1'b0, en, 1'b1, ld, md);
  endtask

  task automatic run(input string tag, input int n, input logic en);
    for (int i = 0; i < n; i++) step(tag, 1'b0, en, 1'b0, 12'h3A5, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int tc_count;
    reset = 1'b1; bus.enable = 1'b0; bus.loadbit = 1'b0; bus.load = '0; bus.mode = 1'b0;
    #1;

    step("reset0", 1'b1, 1'b1, 1'b1, 12'hABC, 1'b1);
    step("reset1", 1'b1, 1'b0, 1'b1, 12'h123, 1'b0);
    check("reset_cont_const", 32'(bus.cont), 32'h0);
    run("idle_en", 3, 1'b1);

    // One-shot from 5: the count reaches 0 on the fifth enabled edge, then holds.
    load_val("os5_load", 12'd5, 1'b0, 1'b0);
    tc_count = 0;
    for (int i = 0; i < 5; i++) begin
      step("os5_run", 1'b0, 1'b1, 1'b0, '0, 1'b0);
      if (bus.tc) tc_count++;
    end
    check("os5_tc_count", 32'(tc_count), 32'd1);
    check("os5_done", 32'(bus.done), 32'd1);
    run("os5_hold", 10, 1'b1);

    // Periodic: period of 3.
    load_val("per3_load", 12'd3, 1'b1, 1'b0);
    tc_count = 0;
    for (int i = 0; i < 9; i++) begin
      step("per3_run", 1'b0, 1'b1, 1'b0, '0, 1'b0);
      if (bus.tc) tc_count++;
    end
    check("per3_tc_count", 32'(tc_count), 32'd3);
    check("per3_cont_end", 32'(bus.cont), 32'd3);

    // Pause.
    load_val("pause_load", 12'h100, 1'b0, 1'b0);
    step("pause_en", 1'b0, 1'b1, 1'b0, '0, 1'b0);
    check("pause_after1", 32'(bus.cont), 32'h0FF);
    step("pause_off", 1'b0, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      step("pause_en", 1'b0, 1'b1, 1'b0, '0, 1'b0);
      step("pause_off", 1'b0, 1'b0, 1'b0, '0, 1'b0);
    end
    check("pause_after16", 32'(bus.cont), 32'h0F0);

    // Load wins over a simultaneous enable.
    load_val("prio_load7", 12'd7, 1'b0, 1'b1);
    check("prio_cont7", 32'(bus.cont), 32'd7);

    // Boundaries.
    load_val("zero_load", 12'd0, 1'b1, 1'b1);
    run("zero_en", 4, 1'b1);
    load_val("one_load", 12'd1, 1'b0, 1'b0);
    step("one_en", 1'b0, 1'b1, 1'b0, '0, 1'b0);
    check("one_done", 32'(bus.done), 32'd1);
    load_val("per1_load", 12'd1, 1'b1, 1'b0);
    run("per1_en", 4, 1'b1);
    run("per1_off", 2, 1'b0);

    load_val("max_load", 12'hFFF, 1'b0, 1'b0);
    n = 0;
    for (int i = 0; i < 5000; i++) begin
      step("max_run", 1'b0, 1'b1, 1'b0, '0, 1'b0);
      n++;
      if (bus.tc) break;
    end
    check("max_edges", 32'(n), 32'd4095);

    // Reset mid-run.
    load_val("mid_load", 12'd10, 1'b1, 1'b0);
    run("mid_run", 4, 1'b1);
    check("mid_cont6", 32'(bus.cont), 32'd6);
    step("mid_reset", 1'b1, 1'b1, 1'b0, '0, 1'b0);
    run("mid_after", 4, 1'b1);
    check("mid_after_cont", 32'(bus.cont), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/contador_descendente.md
Name: contador_descendente

Overview:
- 12-bit loadable down-counter/timer; the counting counterpart of the team's loadable up-counter `contador`.
- Same control style as `contador`: `enable`, `loadbit`, parallel `load`.
- Counts a loaded value down to zero and flags expiry with a terminal-count pulse.
- Supports one-shot and periodic (auto-reload) operation.
- Used as an interval timer / delay generator next to the program counter in lab designs.

Parameters:
- WIDTH, 12, width of `load`, `cont` and the internal reload register.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  count enable; one decrement per rising edge while high.
- loadbit  input  1  parallel-load strobe; captures `load` and `mode`.
- load  input  WIDTH  start/reload value.
- mode  input  1  0 = one-shot, 1 = periodic; sampled only when `loadbit`=1.
- cont  output  WIDTH  current count value (registered).
- tc  output  1  terminal-count pulse; high for exactly one cycle per expiry (registered).
- busy  output  1  high in states ARMED and RUN.
- done  output  1  high in state DONE (one-shot expired).

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high.
- Priority at each rising edge: `reset` > `loadbit` > `enable`.
- Reset:
  - cont=0, tc=0, busy=0, done=0; reload register=0; stored mode=0; state=IDLE.
  - Reset mid-count takes effect on that edge; no tc is issued.
- States: IDLE, ARMED, RUN, DONE. `busy` and `done` are decoded from the state register, so they are glitch-free and registered.
- Load (`loadbit`=1):
  - From any state: cont<=load, reload register<=load, stored mode<=mode, tc<=0.
  - If load != 0: state<=ARMED. If load == 0: state<=IDLE.
  - Any simultaneous `enable` is ignored on that edge.
- IDLE: cont holds; `enable` ignored; tc=0.
- ARMED/RUN, enable=1, loadbit=0:
  - cont>1: cont<=cont-1, state<=RUN, tc<=0.
  - cont==1, one-shot: cont<=0, tc<=1, state<=DONE.
  - cont==1, periodic: cont<=reload register, tc<=1, state<=RUN.
  - Resulting period is exactly N enabled edges for load=N, including N=1 (tc every enabled edge; cont stays 1).
- ARMED/RUN, enable=0: cont and state hold; tc<=0. Pauses do not lose counts.
- DONE: cont=0 held; done=1; `enable` ignored; exit only by `loadbit` or `reset`.
- tc rules:
  - tc is never high on two consecutive cycles unless periodic with reload=1 and enable held high.
  - tc is never asserted on a load edge.
- Arithmetic: unsigned, no wrap-around. cont never underflows past 0 because decrement is only applied when cont>1.
- Maximum load: 2^WIDTH-1 (12'hFFF) counts 4095 enabled edges.

Test Plan:
- Reset: hold reset=1 for 2 edges with arbitrary inputs -> cont=12'h000, tc=0, busy=0, done=0; enable=1 afterwards keeps cont=0.
- One-shot: load=5, mode=0 (1 cycle loadbit), then enable=1 -> cont 5,4,3,2,1,0; tc=1 only in the cycle cont becomes 0; done=1, busy=0 thereafter; cont stays 0 for 10 more enabled cycles.
- Periodic: load=3, mode=1, enable=1 for 9 edges -> cont 3,2,1,3,2,1,3,2,1,3; tc=1 on the 3rd, 6th and 9th edges; done never set.
- Pause and priority:
  - load=12'h100, enable toggled 1/0 every cycle -> cont decrements only on enabled edges (12'h0FF after 1 enabled edge, 12'h0F0 after 16).
  - loadbit=1 and enable=1 together with load=7 -> cont=7, no decrement on that edge.
- Boundaries:
  - load=0 -> state IDLE, busy=0, no tc under enable.
  - load=1, mode=0 -> tc on first enabled edge, done=1.
  - load=12'hFFF, mode=0 -> tc after exactly 4095 enabled edges.
- Reset mid-run: periodic load=10, 4 enabled edges (cont=6), reset=1 for 1 edge -> all outputs 0, state IDLE; enable alone does not restart counting.
